i2f_32_seq: RTL and testbench
=============================

# i2f_32_seq

Sequential 32-bit signed integer to IEEE-754 single-precision converter. It is the inverse companion of the float-to-integer converter in the floating-point library. It accepts one integer per valid/ready handshake and normalizes it iteratively, one bit per cycle. It rounds the result and holds it until the consumer accepts it. It sits between integer datapaths and the float units, trading latency for area.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- d  input  32  signed two's-complement integer operand.
- in_valid  input  1  d is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  output  32  float result {sign, exp[7:0], frac[22:0]}.
- p_lost  output  1  precision lost: result is not exactly equal to d.
- out_valid  output  1  a and p_lost are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1. On in_valid&in_ready, capture sign=d[31] and mag=|d| as 32-bit unsigned; mag for 0x80000000 is 0x80000000.
  - If mag==0, go to DONE with a=0x00000000 and p_lost=0.
  - Otherwise set exp=158 and go to NORM.
- NORM:
  - If mag[31]=1, go to ROUND.
  - Otherwise mag<<=1, exp-=1, and stay in NORM.
- ROUND:
  - frac=mag[30:8], lsb=mag[8], guard=mag[7], sticky=|mag[6:0].
  - Round to nearest even: increment frac when guard&(sticky|lsb).
  - Carry out of frac sets frac=0 and exp+=1.
  - p_lost=guard|sticky. Load a={sign,exp,frac}, then go to DONE.
- DONE:
  - out_valid=1; a and p_lost are held stable.
  - On out_ready, go to IDLE. No new input is accepted in the same cycle.
- exp never exceeds 158, so no overflow, infinity or NaN is ever produced. Denormal outputs cannot occur.
- in_valid outside IDLE is ignored. d is sampled only on the accepting edge.

## Timing
- Reset: state=IDLE, a=0, p_lost=0, out_valid=0, in_ready=1. Any in-flight conversion is discarded and no output is produced.
- in_ready and out_valid are decoded directly from the state register; there is no combinational path from inputs to outputs.
- Latency from the accepting edge to out_valid high:
  - Zero input: 1 cycle.
  - Nonzero input: lz+3 cycles, where lz is the number of leading zeros of mag (0..31). Minimum 3 cycles (d=0x80000000); maximum 34 cycles (d=±1).
- Throughput: one result per (latency + 1 + consumer stall) cycles. in_ready rises the cycle after the out_valid&out_ready edge.
- out_ready held low: DONE persists indefinitely with outputs frozen.
- rst asserted in any state: outputs clear immediately (asynchronously).

## Configuration
- I2F_ROUND_EN defined:
  - Round to nearest even as described.
  - p_lost=guard|sticky.
- I2F_ROUND_EN undefined:
  - Truncate (round toward zero): frac=mag[30:8], no increment, no exponent carry.
  - p_lost is still guard|sticky.
  - Latency and FSM are unchanged; ROUND only assembles the result.

## Test plan
- Reset mid-NORM (d=1 accepted, rst pulsed 5 cycles later) -> out_valid never rises, in_ready=1, a=0.
- d=1 -> a=0x3F800000, p_lost=0, out_valid 34 cycles after accept. d=-1 -> a=0xBF800000.
- d=0x80000000 -> a=0xCF000000, p_lost=0, latency 3. d=0 -> a=0x00000000, p_lost=0, latency 1.
- d=0x7FFFFFFF with I2F_ROUND_EN -> a=0x4F000000, p_lost=1. Without the macro -> a=0x4EFFFFFF, p_lost=1.
- d=0x01000001 (tie) -> a=0x4B800000, p_lost=1. d=0x01000003 -> a=0x4B800002, p_lost=1 (round up, macro on).
- Backpressure: out_ready low 10 cycles with in_valid high and a new d -> a is stable, in_ready=0, the new d is not taken. in_ready rises the cycle after out_ready pulses.

Source files
------------

// File: rtl/i2f_32_seq.sv
// i2f_32_seq: sequential 32-bit signed integer to IEEE-754 single-precision
// converter. Takes one integer per valid/ready handshake, normalizes it one
// bit per cycle, then rounds, packs and holds the result until it is accepted.
//
// Configuration macro:
//   I2F_ROUND_EN  defined   -> round to nearest, ties to even
//                 undefined -> truncate toward zero (default build)
// p_lost reports guard|sticky in both builds.
module i2f_32_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] a,
   output logic        p_lost,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NORM  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Exponent of a value whose leading one sits at bit 31 (127 + 31).
   localparam logic [7:0] EXP_TOP = 8'd158;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic        [31:0] mag_q, mag_d;
   logic        [7:0]  exp_q, exp_d;
   logic        [31:0] a_q, a_d;
   logic               p_lost_q, p_lost_d;

   logic signed [31:0] d_s;
   logic        [31:0] d_mag;
   logic        [32:0] rnd;

   // Magnitude of a two's-complement operand; -2^31 wraps back to 0x80000000,
   // which is exactly the unsigned magnitude we want.
   function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
      logic signed [31:0] neg;
      neg = -v;
      abs_mag = v[31] ? $unsigned(neg) : $unsigned(v);
   endfunction

   // Pack a normalized magnitude (leading one implicit, bits [30:0] given)
   // into {p_lost, sign, exp, frac}.
   function automatic logic [32:0] round_pack(input logic        sign,
                                              input logic [7:0]  exp,
                                              input logic [30:0] m);
      logic [22:0] frac;
      logic        guard;
      logic        sticky;
      logic [7:0]  exp_r;
      logic [22:0] frac_r;
`ifdef I2F_ROUND_EN
      logic        lsb;
      logic        inc;
      logic [23:0] sum;
`endif
      frac   = m[30:8];
      guard  = m[7];
      sticky = |m[6:0];
`ifdef I2F_ROUND_EN
      lsb    = m[8];
      inc    = guard & (sticky | lsb);
      sum    = {1'b0, frac} + {23'd0, inc};
      // A carry out of the fraction leaves frac at zero and bumps the
      // exponent; exp is at most 158 here, so 159 still fits comfortably.
      frac_r = sum[22:0];
      exp_r  = exp + {7'd0, sum[23]};
`else
      frac_r = frac;
      exp_r  = exp;
`endif
      round_pack = {guard | sticky, sign, exp_r, frac_r};
   endfunction

   assign d_s   = d;
   assign d_mag = abs_mag(d_s);
   assign rnd   = round_pack(sign_q, exp_q, mag_q[30:0]);

   // Handshake flags come straight from the state register.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign a         = a_q;
   assign p_lost    = p_lost_q;

   // Next-state and datapath update for the four-state conversion FSM.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      exp_d    = exp_q;
      a_d      = a_q;
      p_lost_d = p_lost_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sign_d = d_s[31];
               mag_d  = d_mag;
               if (d_mag == 32'd0) begin
                  a_d      = 32'd0;
                  p_lost_d = 1'b0;
                  state_d  = S_DONE;
               end else begin
                  exp_d   = EXP_TOP;
                  state_d = S_NORM;
               end
            end
         end
         S_NORM: begin
            if (mag_q[31]) begin
               state_d = S_ROUND;
            end else begin
               mag_d = {mag_q[30:0], 1'b0};
               exp_d = exp_q - 8'd1;
            end
         end
         S_ROUND: begin
            a_d      = rnd[31:0];
            p_lost_d = rnd[32];
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any conversion in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= 32'd0;
         p_lost_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         p_lost_q <= p_lost_d;
      end
   end

   // Working registers; their contents are meaningless outside a conversion.
   always_ff @(posedge clk) begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      exp_q  <= exp_d;
   end

endmodule

// File: tb/tb_i2f_32_seq.sv
// Directed testbench for i2f_32_seq.
module tb_i2f_32_seq;

   logic        clk;
   logic        rst;
   logic [31:0] d;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        p_lost;
   logic        out_valid;
   logic        out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   i2f_32_seq dut (
      .clk       (clk),
      .rst       (rst),
      .d         (d),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .p_lost    (p_lost),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Hand one operand over, then count edges (the accepting edge is 1) until
   // out_valid appears, giving up after 60.
   task automatic convert(input logic [31:0] din, output int lat);
      d        = din;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      d        = 32'hDEAD_BEEF;
      lat      = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Accept the result and confirm the block is ready again the next cycle.
   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
   endtask

   task automatic run_case(input string tag, input logic [31:0] din,
                           input logic [31:0] exp_a, input logic exp_pl,
                           input int exp_lat);
      int lat;
      chk({tag, "_in_ready_before"}, {31'd0, in_ready}, 32'd1);
      convert(din, lat);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_a"}, a, exp_a);
      chk({tag, "_p_lost"}, {31'd0, p_lost}, {31'd0, exp_pl});
      release_out(tag);
   endtask

   initial begin
      int          lat;
      int          rises;
      logic [31:0] held_a;
      logic [31:0] exp_max;
      logic [31:0] exp_up;

      rst       = 1'b1;
      d         = 32'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a", a, 32'd0);
      chk("rst_p_lost", {31'd0, p_lost}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      run_case("one",      32'h0000_0001, 32'h3F80_0000, 1'b0, 34);
      run_case("minus1",   32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 34);

      // Reset in the middle of normalization discards the conversion.
      d        = 32'h0000_0001;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_a", a, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst   = 1'b0;
      rises = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) rises++;
      end
      chk("midrst_no_output", rises, 0);
      chk("midrst_a_after", a, 32'd0);

      run_case("minint",   32'h8000_0000, 32'hCF00_0000, 1'b0, 3);
      run_case("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1);
      run_case("minus6",   32'hFFFF_FFFA, 32'hC0C0_0000, 1'b0, 32);
      run_case("exact24",  32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 11);
`ifdef I2F_ROUND_EN
      exp_max = 32'h4F00_0000;
      exp_up  = 32'h4B80_0002;
`else
      exp_max = 32'h4EFF_FFFF;
      exp_up  = 32'h4B80_0001;
`endif
      run_case("maxint",   32'h7FFF_FFFF, exp_max,       1'b1, 4);
      run_case("tie_even", 32'h0100_0001, 32'h4B80_0000, 1'b1, 10);
      run_case("round_up", 32'h0100_0003, exp_up,        1'b1, 10);

      // Backpressure: result held, new operand refused while DONE.
      convert(32'h0000_0005, lat);
      chk("bp_latency", lat, 32);
      chk("bp_a", a, 32'h40A0_0000);
      held_a   = a;
      d        = 32'h1234_5678;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_a", a, held_a);
         chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("bp_a_after", a, 32'h40A0_0000);
      @(posedge clk); #1;
      chk("bp_not_taken", {31'd0, in_ready}, 32'd1);

      // Block still converts normally after backpressure.
      run_case("post_bp",  32'h0000_0003, 32'h4040_0000, 1'b0, 33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
